// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the M-stage controller (master) and data memory (slave).
// Single outstanding request; the slave completes it by pulsing ready with rdata valid.
interface mem_stage_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MIPS M-stage controller: turns EX/MEM load/store control into a data-memory request,
// stalls the pipeline until the response arrives and formats load data for MEM/WB.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread_m_i,
    input  logic             memwrite_m_i,
    input  logic [1:0]       memsize_m_i,
    input  logic             memunsigned_m_i,
    input  logic [31:0]      addr_m_i,
    input  logic [31:0]      writedata_m_i,
    mem_stage_ctrl_if.master dmem,
    output logic [31:0]      readdata_m_o,
    output logic             stall_m_o,
    output logic             misalign_m_o,
    output logic             buserr_m_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] rdata_q;
    logic        buserr_q;
    logic [7:0]  cnt_q;

    logic        access;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign access     = memread_m_i | memwrite_m_i;
    assign misaligned = ((memsize_m_i == 2'b01) & addr_m_i[0]) |
                        (memsize_m_i[1] & (addr_m_i[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = writedata_m_i;
        case (memsize_m_i)
            2'b00: begin
                be_d    = 4'b0001 << addr_m_i[1:0];
                wdata_d = {4{writedata_m_i[7:0]}};
            end
            2'b01: begin
                be_d    = addr_m_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{writedata_m_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = writedata_m_i;
            end
        endcase
    end

    // Load formatting works from the latched size/lane so EX/MEM is never re-sampled.
    always_comb begin
        byte_sel = dmem.rdata[8*lane_q +: 8];
        half_sel = lane_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (size_q)
            2'b00:   rdata_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   rdata_d = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: rdata_d = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            lane_q   <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rdata_q  <= '0;
                    buserr_q <= 1'b0;
                    cnt_q    <= '0;
                    if (access && !misaligned) begin
                        state_q <= StBusy;
                        req_q   <= 1'b1;
                        we_q    <= memwrite_m_i;
                        addr_q  <= {addr_m_i[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        size_q  <= memsize_m_i;
                        uns_q   <= memunsigned_m_i;
                        lane_q  <= addr_m_i[1:0];
                    end
                end
                StBusy: begin
                    if (dmem.ready) begin
                        state_q <= StDone;
                        req_q   <= 1'b0;
                        rdata_q <= we_q ? 32'h0 : rdata_d;
                        cnt_q   <= '0;
                    end else if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
                        state_q  <= StDone;
                        req_q    <= 1'b0;
                        rdata_q  <= '0;
                        buserr_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    // Always retire: the pipeline advances, so the access must not re-issue.
                    state_q  <= StIdle;
                    buserr_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign stall_m_o    = ~reset & (((state_q == StIdle) & access & ~misaligned) |
                                    (state_q == StBusy));
    assign misalign_m_o = ~reset & (state_q == StIdle) & access & misaligned;
    assign readdata_m_o = (state_q == StDone) ? rdata_q : 32'h0;
    assign buserr_m_o   = (state_q == StDone) & buserr_q;

endmodule
